// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and the host/debug port.
// Each access runs IDLE -> ISSUE -> DONE, so a grant lands two cycles after the request is seen
// and read data follows one cycle later.
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CPU_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_e,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_di,
   input  logic [DATA_W-1:0] mem_do,
   output logic              busy,
   output logic              last_owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Owner encoding: 0 = CPU, 1 = host.
   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                cap_we_q, cap_we_d;
   logic                mem_e_q, mem_e_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_di_q, mem_di_d;
   logic                cpu_gnt_q, cpu_gnt_d;
   logic                host_gnt_q, host_gnt_d;
   logic                cpu_rvalid_q, cpu_rvalid_d;
   logic                host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
   logic                busy_q, busy_d;
   logic                last_owner_q, last_owner_d;
   logic                winner_c;

   // Arbitration: single requester wins; ties go to CPU or alternate with the last owner.
   always_comb begin
      winner_c = host_req;
      if (cpu_req && host_req) begin
         winner_c = (CPU_PRIO != 0) ? 1'b0 : ~last_owner_q;
      end
   end

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      cap_we_d      = cap_we_q;
      mem_e_d       = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_di_d      = mem_di_q;
      cpu_gnt_d     = 1'b0;
      host_gnt_d    = 1'b0;
      cpu_rvalid_d  = 1'b0;
      host_rvalid_d = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      host_rdata_d  = host_rdata_q;
      last_owner_d  = last_owner_q;

      case (state_q)
         IDLE: begin
            if (cpu_req || host_req) begin
               state_d    = ISSUE;
               owner_d    = winner_c;
               cap_we_d   = winner_c ? host_we : cpu_we;
               mem_addr_d = winner_c ? host_addr : cpu_addr;
               mem_di_d   = winner_c ? host_wdata : cpu_wdata;
               mem_e_d    = 1'b1;
               mem_we_d   = winner_c ? host_we : cpu_we;
            end
         end
         ISSUE: begin
            state_d    = DONE;
            cpu_gnt_d  = ~owner_q;
            host_gnt_d = owner_q;
         end
         DONE: begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            if (!cap_we_q) begin
               if (owner_q) begin
                  host_rdata_d  = mem_do;
                  host_rvalid_d = 1'b1;
               end else begin
                  cpu_rdata_d   = mem_do;
                  cpu_rvalid_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset leaves last_owner at host so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         cap_we_q      <= 1'b0;
         mem_e_q       <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_di_q      <= '0;
         cpu_gnt_q     <= 1'b0;
         host_gnt_q    <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
         busy_q        <= 1'b0;
         last_owner_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cap_we_q      <= cap_we_d;
         mem_e_q       <= mem_e_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_di_q      <= mem_di_d;
         cpu_gnt_q     <= cpu_gnt_d;
         host_gnt_q    <= host_gnt_d;
         cpu_rvalid_q  <= cpu_rvalid_d;
         host_rvalid_q <= host_rvalid_d;
         cpu_rdata_q   <= cpu_rdata_d;
         host_rdata_q  <= host_rdata_d;
         busy_q        <= busy_d;
         last_owner_q  <= last_owner_d;
      end
   end

   assign cpu_gnt     = cpu_gnt_q;
   assign cpu_rvalid  = cpu_rvalid_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign host_gnt    = host_gnt_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;
   assign mem_e       = mem_e_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_di      = mem_di_q;
   assign busy        = busy_q;
   assign last_owner  = last_owner_q;

endmodule
